// File: rtl/despachador_pkg.sv
// rtl/despachador_pkg.sv - shared state encoding and default widths for the result-path dispatcher
package despachador_pkg;

    localparam int          PTR_W_DEF     = 2;
    localparam int          BOUNTY_W_DEF  = 24;
    localparam int          NONCE_W_DEF   = 32;
    localparam int          TARGET_W_DEF  = 8;
    localparam logic [31:0] NONCE_LIM_DEF = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        REQ,
        WAIT,
        WRITE,
        DONE
    } estado_t;

endpackage

// File: rtl/contador_nonce.sv
// rtl/contador_nonce.sv - per-entry nonce counter with wrap; limit flag under DESPACHADOR_TIMEOUT_EN
module contador_nonce
    import despachador_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF
`ifdef DESPACHADOR_TIMEOUT_EN
    , parameter logic [NONCE_W-1:0] NONCE_LIM = NONCE_W'(NONCE_LIM_DEF)
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [NONCE_W-1:0] nonce_o
`ifdef DESPACHADOR_TIMEOUT_EN
    , output logic             en_limite_o
`endif
);

    logic [NONCE_W-1:0] cuenta_q;

    // Plain binary add: all-ones rolls over to zero and the search continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else if (clr_i) begin
            cuenta_q <= '0;
        end else if (inc_i) begin
            cuenta_q <= cuenta_q + NONCE_W'(1);
        end
    end

    assign nonce_o = cuenta_q;

`ifdef DESPACHADOR_TIMEOUT_EN
    assign en_limite_o = (cuenta_q == NONCE_LIM);
`endif

endmodule

// File: rtl/despachador_entradas.sv
// rtl/despachador_entradas.sv - walks input entries, searches a nonce per bounty, writes results; DESPACHADOR_TIMEOUT_EN bounds the search
module despachador_entradas
    import despachador_pkg::*;
#(
    parameter int PTR_W    = PTR_W_DEF,
    parameter int BOUNTY_W = BOUNTY_W_DEF,
    parameter int NONCE_W  = NONCE_W_DEF,
    parameter int TARGET_W = TARGET_W_DEF
`ifdef DESPACHADOR_TIMEOUT_EN
    , parameter logic [NONCE_W-1:0] NONCE_LIM = NONCE_W'(NONCE_LIM_DEF)
`endif
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                start,
    input  logic [PTR_W-1:0]    num_entradas,
    input  logic [TARGET_W-1:0] target,
    output logic [PTR_W-1:0]    entry_addr,
    input  logic [BOUNTY_W-1:0] bounty_in,
    output logic                hash_req,
    output logic [BOUNTY_W-1:0] hash_bounty,
    output logic [NONCE_W-1:0]  hash_nonce,
    input  logic                hash_ack,
    input  logic [TARGET_W-1:0] hash_msb,
    output logic                wr_en,
    output logic [PTR_W-1:0]    wr_ptr,
    output logic [BOUNTY_W-1:0] bounty_out,
    output logic [NONCE_W-1:0]  nonce_out,
`ifdef DESPACHADOR_TIMEOUT_EN
    output logic                sin_hit,
`endif
    output logic                valid
);

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    estado_t             estado_q, estado_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [PTR_W-1:0]    num_q, num_d;
    logic [TARGET_W-1:0] target_q, target_d;
    logic [BOUNTY_W-1:0] bounty_q, bounty_d;
    logic [NONCE_W-1:0]  nonce;
    logic                ctr_clr, ctr_inc;
    logic                hit;
`ifdef DESPACHADOR_TIMEOUT_EN
    logic                sin_hit_q, sin_hit_d;
    logic                en_limite;
`endif

    contador_nonce #(
        .NONCE_W   (NONCE_W)
`ifdef DESPACHADOR_TIMEOUT_EN
        , .NONCE_LIM (NONCE_LIM)
`endif
    ) u_contador (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (ctr_clr),
        .inc_i       (ctr_inc),
        .nonce_o     (nonce)
`ifdef DESPACHADOR_TIMEOUT_EN
        , .en_limite_o (en_limite)
`endif
    );

    assign hit = (hash_msb < target_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            target_q  <= '0;
            bounty_q  <= '0;
`ifdef DESPACHADOR_TIMEOUT_EN
            sin_hit_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            target_q  <= target_d;
            bounty_q  <= bounty_d;
`ifdef DESPACHADOR_TIMEOUT_EN
            sin_hit_q <= sin_hit_d;
`endif
        end
    end

    always_comb begin
        estado_d  = estado_q;
        idx_d     = idx_q;
        num_d     = num_q;
        target_d  = target_q;
        bounty_d  = bounty_q;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;
`ifdef DESPACHADOR_TIMEOUT_EN
        sin_hit_d = sin_hit_q;
`endif
        case (estado_q)
            IDLE, DONE: begin
                if (start) begin
                    idx_d    = '0;
                    num_d    = num_entradas;
                    target_d = target;
                    estado_d = LOAD;
                end
            end
            LOAD: estado_d = LATCH;
            LATCH: begin
                bounty_d  = bounty_in;
                ctr_clr   = 1'b1;
`ifdef DESPACHADOR_TIMEOUT_EN
                sin_hit_d = 1'b0;
`endif
                estado_d  = REQ;
            end
            REQ: estado_d = WAIT;
            WAIT: begin
                if (hash_ack) begin
                    if (hit) begin
                        estado_d = WRITE;
`ifdef DESPACHADOR_TIMEOUT_EN
                    end else if (en_limite) begin
                        sin_hit_d = 1'b1;
                        estado_d  = WRITE;
`endif
                    end else begin
                        ctr_inc  = 1'b1;
                        estado_d = REQ;
                    end
                end
            end
            WRITE: begin
                if (idx_q == num_q) begin
                    estado_d = DONE;
                end else begin
                    idx_d    = idx_q + PTR_W'(1);
                    estado_d = LOAD;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Bounty and nonce registers feed both the hash core and the result port.
    assign entry_addr  = idx_q;
    assign hash_req    = (estado_q == REQ);
    assign hash_bounty = bounty_q;
    assign hash_nonce  = nonce;
    assign wr_en       = (estado_q == WRITE);
    assign wr_ptr      = idx_q;
    assign bounty_out  = bounty_q;
    assign nonce_out   = nonce;
    assign valid       = (estado_q == DONE);
`ifdef DESPACHADOR_TIMEOUT_EN
    assign sin_hit     = sin_hit_q;
`endif

endmodule

// File: tb/tb_despachador_entradas.sv
// tb/tb_despachador_entradas.sv - directed scoreboard bench for despachador_entradas
module tb_despachador_entradas;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        start;
    logic [1:0]  num_entradas;
    logic [7:0]  target;
    logic [1:0]  entry_addr;
    logic [23:0] bounty_in;
    logic        hash_req;
    logic [23:0] hash_bounty;
    logic [31:0] hash_nonce;
    logic        hash_ack;
    logic [7:0]  hash_msb;
    logic        wr_en;
    logic [1:0]  wr_ptr;
    logic [23:0] bounty_out;
    logic [31:0] nonce_out;
    logic        valid;
`ifdef DESPACHADOR_TIMEOUT_EN
    logic        sin_hit;
`endif

    typedef struct {
        logic [1:0]  ptr;
        logic [23:0] bounty;
        logic [31:0] nonce;
        logic        sh;
    } res_t;

    res_t        sb_q[$];
    logic [7:0]  resp_q[$];
    logic [7:0]  msb_def;
    logic [23:0] mem[4];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          req_cnt = 0;
    int          last_wr_cyc = -10;
    bit          pending = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

`ifdef DESPACHADOR_TIMEOUT_EN
    despachador_entradas #(.NONCE_LIM(32'd3)) dut (
        .sin_hit      (sin_hit),
`else
    despachador_entradas dut (
`endif
        .clk          (clk),
        .reset_L      (reset_L),
        .start        (start),
        .num_entradas (num_entradas),
        .target       (target),
        .entry_addr   (entry_addr),
        .bounty_in    (bounty_in),
        .hash_req     (hash_req),
        .hash_bounty  (hash_bounty),
        .hash_nonce   (hash_nonce),
        .hash_ack     (hash_ack),
        .hash_msb     (hash_msb),
        .wr_en        (wr_en),
        .wr_ptr       (wr_ptr),
        .bounty_out   (bounty_out),
        .nonce_out    (nonce_out),
        .valid        (valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] n, input logic [7:0] t);
        tick();
        start = 1'b1;
        num_entradas = n;
        target = t;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (valid === 1'b1) break;
            tick();
        end
        chk(tag, valid, 1'b1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (hash_req === 1'b1) break;
            tick();
        end
        chk(tag, hash_req, 1'b1);
    endtask

    // Entry memory: data follows the address by one cycle.
    initial forever begin
        @(negedge clk);
        bounty_in = mem[entry_addr];
    end

    // Hash core: answers one cycle after the request cycle.
    initial forever begin
        @(negedge clk);
        hash_ack = 1'b0;
        if (pending) begin
            hash_ack = 1'b1;
            if (resp_q.size() > 0) hash_msb = resp_q.pop_front();
            else hash_msb = msb_def;
            pending = 1'b0;
        end
        if (hash_req === 1'b1) begin
            pending = 1'b1;
            req_cnt++;
        end
    end

    // Result monitor against scoreboard.
    initial forever begin
        res_t e;
        @(negedge clk);
        if (wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            chk("wr_expected", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wr_ptr", wr_ptr, e.ptr);
                chk("bounty_out", bounty_out, e.bounty);
                chk("nonce_out", nonce_out, e.nonce);
`ifdef DESPACHADOR_TIMEOUT_EN
                chk("sin_hit", sin_hit, e.sh);
`endif
            end
        end
    end

    initial begin
        reset_L = 1'b0;
        start = 1'b0;
        num_entradas = '0;
        target = '0;
        hash_ack = 1'b0;
        hash_msb = '0;
        bounty_in = '0;
        msb_def = 8'hFF;
        mem[0] = 24'hA; mem[1] = 24'hB; mem[2] = 24'hC; mem[3] = 24'hD;
        repeat (3) tick();
        chk("reset_outs", |{entry_addr, hash_req, hash_bounty, hash_nonce, wr_en,
                            wr_ptr, bounty_out, nonce_out, valid}, 1'b0);
        reset_L = 1'b1;
        repeat (4) tick();
        chk("idle_valid", valid, 1'b0);

        // Single entry, hit on second try.
        resp_q = '{8'h20, 8'h05};
        msb_def = 8'hFF;
        sb_q.push_back('{2'd0, 24'hA, 32'd1, 1'b0});
        wr_cnt = 0; req_cnt = 0;
        pulse_start(2'd0, 8'h10);
        wait_valid("t1_valid", 200);
        chk("t1_valid_after_wr", cyc - last_wr_cyc, 1);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_req_cnt", req_cnt, 2);
        chk("t1_sb_empty", sb_q.size(), 0);

        // Four entries, first try hits, restarted from DONE.
        msb_def = 8'h00;
        for (int i = 0; i < 4; i++) sb_q.push_back('{i[1:0], mem[i], 32'd0, 1'b0});
        wr_cnt = 0; req_cnt = 0;
        pulse_start(2'd3, 8'h10);
        chk("t2_valid_cleared", valid, 1'b0);
        wait_valid("t2_valid", 300);
        chk("t2_valid_after_wr", cyc - last_wr_cyc, 1);
        chk("t2_wr_cnt", wr_cnt, 4);
        chk("t2_req_cnt", req_cnt, 4);
        chk("t2_sb_empty", sb_q.size(), 0);

        // Start while busy must not retarget or recount.
        resp_q = '{8'hFF, 8'hFF, 8'hFF};
        msb_def = 8'h00;
        sb_q.push_back('{2'd0, 24'hA, 32'd3, 1'b0});
        sb_q.push_back('{2'd1, 24'hB, 32'd0, 1'b0});
        wr_cnt = 0;
        pulse_start(2'd1, 8'h10);
        wait_req("t3_req", 50);
        tick();
        pulse_start(2'd3, 8'h00);
        wait_valid("t3_valid", 300);
        repeat (10) tick();
        chk("t3_wr_cnt", wr_cnt, 2);
        chk("t3_valid_hold", valid, 1'b1);
        chk("t3_sb_empty", sb_q.size(), 0);

        // Reset during WAIT; a late ack after release must be ignored.
        msb_def = 8'hFF;
        wr_cnt = 0;
        pulse_start(2'd0, 8'h10);
        wait_req("t4_req", 50);
        pending = 1'b0;
        @(posedge clk);
        #1;
        reset_L = 1'b0;
        #1;
        chk("t4_rst_outs", |{entry_addr, hash_req, hash_bounty, hash_nonce, wr_en,
                             wr_ptr, bounty_out, nonce_out, valid}, 1'b0);
        tick();
        reset_L = 1'b1;
        repeat (3) tick();
        msb_def = 8'h00;
        pending = 1'b1;
        req_cnt = 0;
        repeat (20) tick();
        chk("t4_wr_cnt", wr_cnt, 0);
        chk("t4_req_cnt", req_cnt, 0);
        chk("t4_idle_outs", |{entry_addr, hash_req, hash_bounty, hash_nonce, wr_en,
                              wr_ptr, bounty_out, nonce_out, valid}, 1'b0);

        // target=0: never a hit.
        msb_def = 8'h00;
        wr_cnt = 0; req_cnt = 0;
`ifdef DESPACHADOR_TIMEOUT_EN
        sb_q.push_back('{2'd0, 24'hA, 32'd3, 1'b1});
        pulse_start(2'd0, 8'h00);
        wait_valid("t5_valid", 200);
        chk("t5_req_cnt", req_cnt, 4);
        chk("t5_wr_cnt", wr_cnt, 1);
        chk("t5_sb_empty", sb_q.size(), 0);
`else
        pulse_start(2'd0, 8'h00);
        repeat (1000) tick();
        chk("t5_wr_cnt", wr_cnt, 0);
        chk("t5_valid", valid, 1'b0);
        chk("t5_searching", req_cnt > 100, 1'b1);
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
